// File: rtl/gsm_pkg.sv
// Shared GSM constants: sample width, 4-ASK levels, Gray mapper and PRBS definition.
// The downstream BER checker imports the same LFSR constants so both ends agree.
package gsm_pkg;

    localparam int GSM_WIDTH = 18;

    localparam logic signed [GSM_WIDTH-1:0] LEVEL_A  = 18'sd32768;
    localparam logic signed [GSM_WIDTH-1:0] LEVEL_3A = 18'sd98304;

    // PRBS x^15 + x^14 + 1, shifting towards the MSB
    localparam int                  LFSR_LEN   = 15;
    localparam int                  LFSR_TAP_A = 14;
    localparam int                  LFSR_TAP_B = 13;
    localparam logic [LFSR_LEN-1:0] LFSR_SEED  = 15'h7FFF;

    function automatic logic signed [GSM_WIDTH-1:0] gsm_map_a(
        input logic [1:0]                  s,
        input logic signed [GSM_WIDTH-1:0] a
    );
        logic signed [GSM_WIDTH-1:0] a3;
        a3 = a + a + a;
        case (s)
            2'b00:   gsm_map_a = -a3;
            2'b01:   gsm_map_a = -a;
            2'b11:   gsm_map_a = a;
            default: gsm_map_a = a3;
        endcase
    endfunction

    function automatic logic signed [GSM_WIDTH-1:0] gsm_map(input logic [1:0] s);
        return gsm_map_a(s, LEVEL_A);
    endfunction

    function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] st);
        return {st[LFSR_LEN-2:0], st[LFSR_TAP_A] ^ st[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/gsm_clk_en_gen.sv
// Sample/symbol enable generator: sys_clk divider plus samples-per-symbol phase counter.
// sam_tick/fetch are the combinational "next edge raises the enable" pulses.
module gsm_clk_en_gen #(
    parameter int SAM_DIV = 4,
    parameter int SPS     = 4
) (
    input  logic sys_clk,
    input  logic reset,
    output logic sam_clk_en,
    output logic sym_clk_en,
    output logic sam_tick,
    output logic fetch
);

    localparam int DIV_W = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
    localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAM_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [PH_W-1:0]  ph_reg, ph_next;
    logic             sam_en_reg, sym_en_reg;

    always_comb begin
        sam_tick = (div_reg == DIV_LAST);
        fetch    = sam_tick && (ph_reg == PH_LAST);
        div_next = sam_tick ? '0 : div_reg + 1'b1;
        ph_next  = ph_reg;
        if (sam_tick) begin
            ph_next = (ph_reg == PH_LAST) ? '0 : ph_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_reg    <= '0;
            ph_reg     <= '0;
            sam_en_reg <= 1'b0;
            sym_en_reg <= 1'b0;
        end else begin
            div_reg    <= div_next;
            ph_reg     <= ph_next;
            sam_en_reg <= sam_tick;
            sym_en_reg <= fetch;
        end
    end

    assign sam_clk_en = sam_en_reg;
    assign sym_clk_en = sym_en_reg;

endmodule

// File: rtl/gsm_symbol_source.sv
// 4-ASK symbol source for the GSM pulse-shaping filter: PRBS or external symbols,
// Gray-mapped and zero-stuffed to SPS samples per symbol, one sample every SAM_DIV clocks.
module gsm_symbol_source #(
    parameter int                 WIDTH     = gsm_pkg::GSM_WIDTH,
    parameter int                 SAM_DIV   = 4,
    parameter int                 SPS       = 4,
    parameter logic signed [17:0] LEVEL_A   = gsm_pkg::LEVEL_A,
    parameter logic [14:0]        LFSR_SEED = gsm_pkg::LFSR_SEED
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    ext_mode,
    input  logic [1:0]              sym_in,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    output logic                    sam_clk_en,
    output logic                    sym_clk_en,
    output logic signed [WIDTH-1:0] x_out,
    output logic [1:0]              sym_out,
    output logic                    underrun
);

    import gsm_pkg::*;

    logic                    sam_tick;
    logic                    fetch;
    logic [LFSR_LEN-1:0]     lfsr_reg, lfsr_next;
    logic signed [WIDTH-1:0] x_reg;
    logic [1:0]              sym_out_reg;
    logic                    underrun_reg;
    logic [1:0]              sym_sel;
    logic                    emit;

    gsm_clk_en_gen #(
        .SAM_DIV (SAM_DIV),
        .SPS     (SPS)
    ) u_clk_en_gen (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .sam_tick   (sam_tick),
        .fetch      (fetch)
    );

    // run and ext_mode only matter on the fetch edge, so mid-symbol changes never glitch
    always_comb begin
        sym_sel   = ext_mode ? sym_in : {lfsr_reg[LFSR_TAP_A], lfsr_reg[LFSR_TAP_B]};
        emit      = run && (!ext_mode || sym_valid);
        lfsr_next = lfsr_reg;
        if (fetch && run && !ext_mode) begin
            lfsr_next = lfsr_step(lfsr_step(lfsr_reg));
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg     <= LFSR_SEED;
            x_reg        <= '0;
            sym_out_reg  <= '0;
            underrun_reg <= 1'b0;
        end else begin
            lfsr_reg <= lfsr_next;
            if (fetch) begin
                x_reg <= emit ? WIDTH'(gsm_map_a(sym_sel, LEVEL_A)) : '0;
                if (emit) begin
                    sym_out_reg <= sym_sel;
                end
                if (run && ext_mode && !sym_valid) begin
                    underrun_reg <= 1'b1;
                end
            end else if (sam_tick) begin
                x_reg <= '0;
            end
        end
    end

    assign sym_ready = fetch && ext_mode && run;
    assign x_out     = x_reg;
    assign sym_out   = sym_out_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_gsm_symbol_source.sv
// Self-checking bench for gsm_symbol_source: cycle-count timing model plus a PRBS bit-recurrence model.
module tb_gsm_symbol_source;

    logic              sys_clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic              ext_mode = 1'b0;
    logic [1:0]        sym_in = 2'b00;
    logic              sym_valid = 1'b0;
    logic              sym_ready;
    logic              sam_clk_en;
    logic              sym_clk_en;
    logic signed [17:0] x_out;
    logic [1:0]        sym_out;
    logic              underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit prbs_bits [0:4095];

    int                 prbs_idx = 0;
    logic signed [17:0] m_level  = '0;
    logic [1:0]         m_sym    = '0;
    logic               m_under  = 1'b0;

    gsm_symbol_source dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .run        (run),
        .ext_mode   (ext_mode),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .x_out      (x_out),
        .sym_out    (sym_out),
        .underrun   (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic logic signed [17:0] lvl(input logic [1:0] s);
        case (s)
            2'b00:   return -18'sd98304;
            2'b01:   return -18'sd32768;
            2'b11:   return 18'sd32768;
            default: return 18'sd98304;
        endcase
    endfunction

    // Per-cycle model: enables follow cycle count; a symbol decided at the fetch cycle shows for 4 cycles
    always @(negedge sys_clk) begin
        int c;
        if (!reset) begin
            prbs_idx = 0;
            m_level  = '0;
            m_sym    = '0;
            m_under  = 1'b0;
            chk("rst_x_out", $signed(x_out), 0);
            chk("rst_sam_en", sam_clk_en, 0);
            chk("rst_sym_en", sym_clk_en, 0);
            chk("rst_ready", sym_ready, 0);
            chk("rst_sym_out", sym_out, 0);
            chk("rst_underrun", underrun, 0);
        end else begin
            c = cyc;
            chk("sam_clk_en", sam_clk_en, (c != 0 && c % 4 == 0));
            chk("sym_clk_en", sym_clk_en, (c != 0 && c % 16 == 0));
            chk("sym_ready", sym_ready, (c % 16 == 15) && ext_mode && run);
            chk("x_out", $signed(x_out), (c % 16 < 4) ? m_level : 18'sd0);
            chk("sym_out", sym_out, m_sym);
            chk("underrun", underrun, m_under);
            if (c % 16 == 15) begin
                if (run && !ext_mode) begin
                    m_sym   = {prbs_bits[2*prbs_idx], prbs_bits[2*prbs_idx+1]};
                    m_level = lvl(m_sym);
                    prbs_idx++;
                end else if (run && sym_valid) begin
                    m_sym   = sym_in;
                    m_level = lvl(m_sym);
                end else begin
                    m_level = '0;
                    if (run) m_under = 1'b1;
                end
            end
        end
    end

    task automatic next_sym();
        do begin
            @(posedge sys_clk);
            #1;
        end while (cyc % 16 != 0);
    endtask

    initial begin
        // Output bit stream of the seeded LFSR: s[n+15] = s[n] ^ s[n+1]
        for (int n = 0; n < 4096; n++) begin
            prbs_bits[n] = (n < 15) ? 1'b1 : (prbs_bits[n-15] ^ prbs_bits[n-14]);
        end
        chk("model_sym0", {prbs_bits[0], prbs_bits[1]}, 2'b11);
        chk("model_sym7", {prbs_bits[14], prbs_bits[15]}, 2'b10);
        chk("model_sym8", {prbs_bits[16], prbs_bits[17]}, 2'b00);
        chk("model_bit29", prbs_bits[29], 1);

        // 1: reset release, run=0
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 chk("t1_sam_cyc3", sam_clk_en, 0);
        @(posedge sys_clk);
        #1 chk("t1_sam_cyc4", sam_clk_en, 1);
        repeat (60) @(posedge sys_clk);
        #1;

        // 2: PRBS from seed, 1000 symbols
        next_sym();
        run = 1'b1;
        ext_mode = 1'b0;
        next_sym();
        chk("t2_first_level", $signed(x_out), 32768);
        chk("t2_first_sym", sym_out, 2'b11);
        repeat (4) @(posedge sys_clk);
        #1 chk("t2_stuffed_zero", $signed(x_out), 0);
        repeat (999) next_sym();

        // 3: external symbols, always valid
        ext_mode = 1'b1;
        sym_valid = 1'b1;
        sym_in = 2'b10;
        next_sym();
        chk("t3_lvl_10", $signed(x_out), 98304);
        sym_in = 2'b00;
        next_sym();
        chk("t3_lvl_00", $signed(x_out), -98304);
        sym_in = 2'b01;
        next_sym();
        chk("t3_lvl_01", $signed(x_out), -32768);
        sym_in = 2'b11;
        next_sym();
        chk("t3_lvl_11", $signed(x_out), 32768);

        // 4: one missing external symbol
        sym_valid = 1'b0;
        sym_in = 2'b10;
        next_sym();
        chk("t4_silent", $signed(x_out), 0);
        chk("t4_underrun", underrun, 1);
        sym_valid = 1'b1;
        sym_in = 2'b01;
        next_sym();
        chk("t4_recover", $signed(x_out), -32768);
        chk("t4_sticky", underrun, 1);

        // 5: run dropped and restored mid-symbol, PRBS resumes where it stopped
        ext_mode = 1'b0;
        next_sym();
        repeat (5) @(posedge sys_clk);
        #1 run = 1'b0;
        next_sym();
        chk("t5_idle", $signed(x_out), 0);
        repeat (2) next_sym();
        repeat (7) @(posedge sys_clk);
        #1 run = 1'b1;
        repeat (3) next_sym();

        // 6: asynchronous reset mid-symbol, off the clock edge
        repeat (6) @(posedge sys_clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_x_out", $signed(x_out), 0);
        chk("t6_sam_en", sam_clk_en, 0);
        chk("t6_sym_out", sym_out, 0);
        chk("t6_underrun", underrun, 0);
        run = 1'b0;
        ext_mode = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 chk("t6_sam_cyc3", sam_clk_en, 0);
        @(posedge sys_clk);
        #1 chk("t6_sam_cyc4", sam_clk_en, 1);
        repeat (60) @(posedge sys_clk);
        #1;
        next_sym();
        run = 1'b1;
        next_sym();
        chk("t6_reseeded", $signed(x_out), 32768);
        repeat (3) next_sym();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
